dllp_tx_scheduler: RTL and testbench

- Decides when the TX data link layer issues Ack, Nak, PM and UpdateFC DLLPs, and drives the one-cycle request strobes into the DLLP creator.
- Coalesces Acks using a latency timer and a TLP count. Runs the periodic UpdateFC timer. Arbitrates pending DLLP types by fixed priority.
- Handshakes with the TX arbiter (req/gnt) so that no DLLP is issued while the link slot is not free.

---
 rtl/dl_tx_pkg.sv | 36 +++
 rtl/dllp_prio_sel.sv | 25 ++
 rtl/dllp_tx_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_dllp_tx_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_tx_pkg.sv
// Shared types and default sizing for the TX data link layer DLLP scheduling logic.
package dl_tx_pkg;

    localparam int unsigned SEQ_NUM_WIDTH_DEF  = 12;
    localparam int unsigned ACK_LAT_CYCLES_DEF = 64;
    localparam int unsigned ACK_COALESCE_DEF   = 4;
    localparam int unsigned UPDFC_PERIOD_DEF   = 1024;
    localparam int unsigned TIMER_W_DEF        = 11;

    typedef enum logic [2:0] {
        DK_NONE,
        DK_NAK,
        DK_ACK,
        DK_PM,
        DK_UPDFC
    } dllp_kind_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE
    } sched_state_e;

    typedef enum logic [1:0] {
        PM_ENTER_L1         = 2'd0,
        PM_ENTER_L23        = 2'd1,
        PM_ACTIVE_STATE_REQ = 2'd2,
        PM_REQUEST_ACK      = 2'd3
    } pm_type_e;

    // Bit order: {request_ack, active_state_req, enter_l23, enter_l1}
    function automatic logic [3:0] pm_onehot(input pm_type_e t);
        pm_onehot = 4'b0001 << t;
    endfunction

endpackage

// File: rtl/dllp_prio_sel.sv
// Fixed-priority pick among pending DLLP types: Nak, then Ack, then PM, then UpdateFC.
module dllp_prio_sel
    import dl_tx_pkg::*;
(
    input  logic       nak_pend,
    input  logic       ack_pend,
    input  logic       pm_pend,
    input  logic       upd_pend,
    output dllp_kind_e kind
);

    always_comb begin
        kind = DK_NONE;
        if (nak_pend) begin
            kind = DK_NAK;
        end else if (ack_pend) begin
            kind = DK_ACK;
        end else if (pm_pend) begin
            kind = DK_PM;
        end else if (upd_pend) begin
            kind = DK_UPDFC;
        end
    end

endmodule

// File: rtl/dllp_tx_scheduler.sv
// Schedules Ack/Nak/PM/UpdateFC DLLPs: Ack coalescing, periodic UpdateFC timer,
// and a req/gnt handshake with the TX arbiter that yields one-cycle creator strobes.
module dllp_tx_scheduler
    import dl_tx_pkg::*;
#(
    parameter int unsigned SEQ_NUM_WIDTH  = SEQ_NUM_WIDTH_DEF,
    parameter int unsigned ACK_LAT_CYCLES = ACK_LAT_CYCLES_DEF,
    parameter int unsigned ACK_COALESCE   = ACK_COALESCE_DEF,
    parameter int unsigned UPDFC_PERIOD   = UPDFC_PERIOD_DEF,
    parameter int unsigned TIMER_W        = TIMER_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dl_active,
    input  logic                     rx_tlp_good,
    input  logic [SEQ_NUM_WIDTH-1:0] rx_seq_num,
    input  logic                     rx_tlp_bad,
    input  logic                     fc_update_req,
    input  logic                     pm_req,
    input  logic [1:0]               pm_type,
    input  logic                     dllp_gnt,
    output logic                     dllp_req,
    output logic                     gen_ack,
    output logic                     gen_nak,
    output logic                     gen_pm,
    output logic                     pm_enter_l1,
    output logic                     pm_enter_l23,
    output logic                     pm_active_state_req,
    output logic                     pm_request_ack,
    output logic                     transmit_update_dllp,
    output logic [SEQ_NUM_WIDTH-1:0] ack_nak_seq_num
);

    localparam int unsigned CNT_W = $clog2(ACK_COALESCE + 1);
    localparam logic [TIMER_W-1:0] ACK_LAST   = TIMER_W'(ACK_LAT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FC_LAST    = TIMER_W'(UPDFC_PERIOD - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   COALESCE_N = CNT_W'(ACK_COALESCE);

    sched_state_e state, state_next;
    dllp_kind_e   winner, sel_kind, issue_kind;
    logic         grant;

    logic [SEQ_NUM_WIDTH-1:0] last_good_seq, seq_next;
    logic [CNT_W-1:0]         unack_cnt, unack_base, unack_next;
    logic [TIMER_W-1:0]       ack_tmr, ack_tmr_next;
    logic [TIMER_W-1:0]       fc_tmr, fc_tmr_next;
    logic                     ack_pend, ack_pend_next, ack_clr;
    logic                     nak_pend, nak_pend_next, nak_accept;
    logic                     nak_scheduled, sched_after_good, nak_sched_next;
    logic                     pm_pend, pm_pend_next;
    logic                     upd_pend, upd_pend_next;
    pm_type_e                 pm_type_q;

    dllp_prio_sel u_prio_sel (
        .nak_pend (nak_pend),
        .ack_pend (ack_pend),
        .pm_pend  (pm_pend),
        .upd_pend (upd_pend),
        .kind     (sel_kind)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next           = state;
        grant                = 1'b0;
        issue_kind           = DK_NONE;
        dllp_req             = 1'b0;
        gen_ack              = 1'b0;
        gen_nak              = 1'b0;
        gen_pm               = 1'b0;
        transmit_update_dllp = 1'b0;
        {pm_request_ack, pm_active_state_req, pm_enter_l23, pm_enter_l1} = 4'b0000;
        case (state)
            IDLE: begin
                if (dl_active && (sel_kind != DK_NONE)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                dllp_req = 1'b1;
                if (!dl_active) begin
                    state_next = IDLE;
                end else if (dllp_gnt && (sel_kind != DK_NONE)) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = IDLE;
                // A link drop during the issue cycle suppresses the strobe.
                if (dl_active) begin
                    issue_kind = winner;
                    case (winner)
                        DK_ACK:   gen_ack = 1'b1;
                        DK_NAK:   gen_nak = 1'b1;
                        DK_PM: begin
                            gen_pm = 1'b1;
                            {pm_request_ack, pm_active_state_req, pm_enter_l23, pm_enter_l1} =
                                pm_onehot(pm_type_q);
                        end
                        DK_UPDFC: transmit_update_dllp = 1'b1;
                        default:  ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        seq_next = rx_tlp_good ? rx_seq_num : last_good_seq;

        // Flags are cleared at the end of the issue cycle; a new event in that cycle re-sets them.
        ack_clr    = (issue_kind == DK_ACK) || (issue_kind == DK_NAK);
        unack_base = ack_clr ? '0 : unack_cnt;
        unack_next = unack_base;
        if (rx_tlp_good && (unack_base != CNT_MAX)) begin
            unack_next = unack_base + 1'b1;
        end

        ack_tmr_next = '0;
        if (unack_base != '0) begin
            ack_tmr_next = (ack_tmr == ACK_LAST) ? ack_tmr : ack_tmr + 1'b1;
        end
        ack_pend_next = (unack_next >= COALESCE_N)
                     || ((unack_next != '0) && (ack_tmr_next == ACK_LAST))
                     || (ack_pend && !ack_clr);

        sched_after_good = rx_tlp_good ? 1'b0 : nak_scheduled;
        nak_accept       = rx_tlp_bad && !sched_after_good;
        nak_sched_next   = nak_accept || sched_after_good;
        nak_pend_next    = nak_accept || (nak_pend && (issue_kind != DK_NAK));

        pm_pend_next = pm_req || (pm_pend && (issue_kind != DK_PM));

        fc_tmr_next = fc_tmr + 1'b1;
        if ((grant && (sel_kind == DK_UPDFC)) || (fc_tmr == FC_LAST)) begin
            fc_tmr_next = '0;
        end
        upd_pend_next = fc_update_req || (fc_tmr_next == FC_LAST)
                     || (upd_pend && (issue_kind != DK_UPDFC));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            winner          <= DK_NONE;
            last_good_seq   <= '1;
            ack_nak_seq_num <= '0;
            unack_cnt       <= '0;
            ack_tmr         <= '0;
            fc_tmr          <= '0;
            ack_pend        <= 1'b0;
            nak_pend        <= 1'b0;
            nak_scheduled   <= 1'b0;
            pm_pend         <= 1'b0;
            upd_pend        <= 1'b0;
            pm_type_q       <= PM_ENTER_L1;
        end else if (!dl_active) begin
            unack_cnt     <= '0;
            ack_tmr       <= '0;
            fc_tmr        <= '0;
            ack_pend      <= 1'b0;
            nak_pend      <= 1'b0;
            nak_scheduled <= 1'b0;
            pm_pend       <= 1'b0;
            upd_pend      <= 1'b0;
        end else begin
            if (grant) begin
                winner <= sel_kind;
                if ((sel_kind == DK_ACK) || (sel_kind == DK_NAK)) begin
                    ack_nak_seq_num <= seq_next;
                end
            end
            last_good_seq <= seq_next;
            unack_cnt     <= unack_next;
            ack_tmr       <= ack_tmr_next;
            fc_tmr        <= fc_tmr_next;
            ack_pend      <= ack_pend_next;
            nak_pend      <= nak_pend_next;
            nak_scheduled <= nak_sched_next;
            pm_pend       <= pm_pend_next;
            upd_pend      <= upd_pend_next;
            if (pm_req) begin
                pm_type_q <= pm_type_e'(pm_type);
            end
        end
    end

endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// Directed bench for dllp_tx_scheduler with hand-computed strobe timing and sequence numbers.
module tb_dllp_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        dl_active;
    logic        rx_tlp_good;
    logic [11:0] rx_seq_num;
    logic        rx_tlp_bad;
    logic        fc_update_req;
    logic        pm_req;
    logic [1:0]  pm_type;
    logic        dllp_gnt;
    logic        dllp_req;
    logic        gen_ack;
    logic        gen_nak;
    logic        gen_pm;
    logic        pm_enter_l1;
    logic        pm_enter_l23;
    logic        pm_active_state_req;
    logic        pm_request_ack;
    logic        transmit_update_dllp;
    logic [11:0] ack_nak_seq_num;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dllp_tx_scheduler #(
        .SEQ_NUM_WIDTH  (12),
        .ACK_LAT_CYCLES (64),
        .ACK_COALESCE   (4),
        .UPDFC_PERIOD   (1024),
        .TIMER_W        (11)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .dl_active            (dl_active),
        .rx_tlp_good          (rx_tlp_good),
        .rx_seq_num           (rx_seq_num),
        .rx_tlp_bad           (rx_tlp_bad),
        .fc_update_req        (fc_update_req),
        .pm_req               (pm_req),
        .pm_type              (pm_type),
        .dllp_gnt             (dllp_gnt),
        .dllp_req             (dllp_req),
        .gen_ack              (gen_ack),
        .gen_nak              (gen_nak),
        .gen_pm               (gen_pm),
        .pm_enter_l1          (pm_enter_l1),
        .pm_enter_l23         (pm_enter_l23),
        .pm_active_state_req  (pm_active_state_req),
        .pm_request_ack       (pm_request_ack),
        .transmit_update_dllp (transmit_update_dllp),
        .ack_nak_seq_num      (ack_nak_seq_num)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        dl_active     = 1'b1;
        rx_tlp_good   = 1'b0;
        rx_seq_num    = '0;
        rx_tlp_bad    = 1'b0;
        fc_update_req = 1'b0;
        pm_req        = 1'b0;
        pm_type       = 2'd0;
        dllp_gnt      = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return gen_ack;
            1:       return gen_nak;
            2:       return gen_pm;
            3:       return transmit_update_dllp;
            default: return dllp_req;
        endcase
    endfunction

    // Returns the tick count at which the selected output was first seen high, or -1 on timeout.
    task automatic wait_for(input int sel, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (sig(sel)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_window(input int len, output int acks, output int naks,
                                output int pms, output int upds);
        acks = 0; naks = 0; pms = 0; upds = 0;
        for (int i = 0; i < len; i++) begin
            tick();
            acks += int'(gen_ack);
            naks += int'(gen_nak);
            pms  += int'(gen_pm);
            upds += int'(transmit_update_dllp);
        end
    endtask

    task automatic send_good(input logic [11:0] seq);
        rx_tlp_good = 1'b1;
        rx_seq_num  = seq;
        tick();
        rx_tlp_good = 1'b0;
    endtask

    task automatic send_bad();
        rx_tlp_bad = 1'b1;
        tick();
        rx_tlp_bad = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, a, k, p, u;
        int t_nak, t_pm, t_upd, t_upd2, n_upd;
        logic [11:0] nak_seq;
        logic [3:0]  pm_q;

        // Ack forced by the latency timer: first TLP edge + 65 edges to strobe.
        do_reset();
        dllp_gnt = 1'b1;
        check("t1_reset_outputs", {dllp_req, gen_ack, gen_nak, gen_pm, transmit_update_dllp,
                                   ack_nak_seq_num}, 0);
        send_good(12'd5);
        send_good(12'd6);
        send_good(12'd7);
        wait_for(0, 200, n);
        check("t1_ack_latency", n, 63);
        check("t1_ack_seq", ack_nak_seq_num, 12'd7);
        check("t1_req_low_in_issue", dllp_req, 1'b0);

        // Ack forced by coalescing four TLPs.
        do_reset();
        dllp_gnt = 1'b1;
        for (int i = 0; i < 4; i++) send_good(12'(i));
        wait_for(0, 20, n);
        check("t2_ack_latency", n, 2);
        check("t2_ack_seq", ack_nak_seq_num, 12'd3);
        count_window(80, a, k, p, u);
        check("t2_no_second_ack", a, 0);

        // Nak held off by the arbiter, duplicate bad TLP ignored.
        do_reset();
        send_good(12'd10);
        send_bad();
        send_bad();
        count_window(20, a, k, p, u);
        check("t3_no_strobe_wo_gnt", a + k + p + u, 0);
        check("t3_req_held", dllp_req, 1'b1);
        dllp_gnt = 1'b1;
        wait_for(1, 10, n);
        check("t3_nak_latency", n, 1);
        check("t3_nak_seq", ack_nak_seq_num, 12'd10);
        count_window(100, a, k, p, u);
        check("t3_single_nak", k, 0);
        check("t3_no_ack_after_nak", a, 0);
        send_bad();
        count_window(10, a, k, p, u);
        check("t3_bad_while_scheduled", k, 0);
        send_good(12'd11);
        send_bad();
        wait_for(1, 10, n);
        check("t3_rearm_latency", n, 2);
        check("t3_rearm_seq", ack_nak_seq_num, 12'd11);

        // Simultaneous Nak, PM and UpdateFC: priority order and spacing.
        do_reset();
        dllp_gnt      = 1'b1;
        rx_tlp_bad    = 1'b1;
        fc_update_req = 1'b1;
        pm_req        = 1'b1;
        pm_type       = 2'd1;
        tick();
        rx_tlp_bad    = 1'b0;
        fc_update_req = 1'b0;
        pm_req        = 1'b0;
        t_nak = -1; t_pm = -1; t_upd = -1; nak_seq = '0; pm_q = '0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (gen_nak && t_nak < 0) begin
                t_nak   = i;
                nak_seq = ack_nak_seq_num;
            end
            if (gen_pm && t_pm < 0) begin
                t_pm = i;
                pm_q = {pm_request_ack, pm_active_state_req, pm_enter_l23, pm_enter_l1};
            end
            if (transmit_update_dllp && t_upd < 0) t_upd = i;
        end
        check("t4_nak_tick", t_nak, 2);
        check("t4_pm_tick", t_pm, 5);
        check("t4_upd_tick", t_upd, 8);
        check("t4_pm_l23_onehot", pm_q, 4'b0010);
        check("t4_nak_seq_all_ones", nak_seq, 12'hFFF);

        // Periodic UpdateFC on an otherwise idle link.
        do_reset();
        dllp_gnt = 1'b1;
        t_upd = -1; t_upd2 = -1; n_upd = 0;
        for (int i = 1; i <= 2100; i++) begin
            tick();
            if (transmit_update_dllp) begin
                n_upd++;
                if (t_upd < 0) t_upd = i;
                else if (t_upd2 < 0) t_upd2 = i;
            end
        end
        check("t5_upd_count", n_upd, 2);
        check("t5_upd_first", t_upd, 1025);
        check("t5_upd_second", t_upd2, 2050);

        // dl_active drop while requesting, then reset and a fresh Ack.
        do_reset();
        for (int i = 0; i < 4; i++) send_good(12'(i));
        tick();
        check("t6_req_before_drop", dllp_req, 1'b1);
        dl_active = 1'b0;
        dllp_gnt  = 1'b1;
        tick();
        check("t6_req_after_drop", dllp_req, 1'b0);
        count_window(5, a, k, p, u);
        check("t6_no_strobe_inactive", a + k + p + u, 0);
        dl_active = 1'b1;
        count_window(80, a, k, p, u);
        check("t6_flags_flushed", a + k + p + u, 0);
        send_bad();
        wait_for(1, 10, n);
        check("t6_nak_latency", n, 2);
        check("t6_seq_held", ack_nak_seq_num, 12'd3);
        rst = 1'b0;
        tick();
        check("t6_reset_outputs", {dllp_req, gen_ack, gen_nak, gen_pm, pm_enter_l1, pm_enter_l23,
                                   pm_active_state_req, pm_request_ack, transmit_update_dllp,
                                   ack_nak_seq_num}, 0);
        rst = 1'b1;
        send_good(12'd20);
        wait_for(0, 100, n);
        check("t6_ack_latency", n, 65);
        check("t6_ack_seq", ack_nak_seq_num, 12'd20);

        // PM type overwrite and sequence wrap through zero.
        do_reset();
        pm_req  = 1'b1;
        pm_type = 2'd0;
        tick();
        pm_type = 2'd3;
        tick();
        pm_req   = 1'b0;
        dllp_gnt = 1'b1;
        wait_for(2, 10, n);
        check("t7_pm_latency", n, 1);
        check("t7_pm_overwrite", {pm_request_ack, pm_active_state_req, pm_enter_l23, pm_enter_l1},
              4'b1000);
        send_good(12'd4095);
        send_good(12'd0);
        send_good(12'd1);
        send_good(12'd2);
        wait_for(0, 20, n);
        check("t7_wrap_ack_latency", n, 2);
        check("t7_wrap_ack_seq", ack_nak_seq_num, 12'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
